fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_ctrl_if.sv | 37 +++
 rtl/fifo_rd_ctrl.sv | 141 ++++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_ctrl_if.sv
// Handshake bundle between fifo_rd_ctrl, its upstream FIFO and the downstream stream sink.
// Defining FIFO_RD_CHECKSUM_EN adds the checksum signal to the bundle.
interface fifo_rd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 5
);
  logic                  start;
  logic [LEN_WIDTH-1:0]  burst_len;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dataout;
  logic                  fifo_re;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  done;
  logic [LEN_WIDTH-1:0]  word_cnt;
`ifdef FIFO_RD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum;
`endif

  modport slave (
    input  start, burst_len, fifo_empty, fifo_dataout, out_ready,
    output fifo_re, out_data, out_valid, busy, done, word_cnt
`ifdef FIFO_RD_CHECKSUM_EN
    , output checksum
`endif
  );

  modport master (
    output start, burst_len, fifo_empty, fifo_dataout, out_ready,
    input  fifo_re, out_data, out_valid, busy, done, word_cnt
`ifdef FIFO_RD_CHECKSUM_EN
    , input checksum
`endif
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Burst read controller: pulls burst_len words from a 1-cycle-latency FIFO into a 2-entry skid buffer
// and streams them out with valid/ready. Optional FIFO_RD_CHECKSUM_EN adds a running checksum output.
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 5
) (
  input  logic          clk,
  input  logic          rst,
  fifo_rd_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic [LEN_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pop;
  logic                  re;
  logic [2:0]            pending;
`ifdef FIFO_RD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

  always_comb begin
    pop     = (occ_q != 2'd0) && bus.out_ready;
    // A word leaving this cycle frees its slot, so steady streaming keeps one read per cycle.
    pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    re      = (state_q == READ) && !bus.fifo_empty && (issued_q < len_q) && (pending < 3'd2);

    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    word_cnt_d = word_cnt_q;
    occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    mem_d      = mem_q;
    inflight_d = re;
`ifdef FIFO_RD_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    if (inflight_q) begin
      mem_d[wr_ptr_q] = bus.fifo_dataout;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d   = ~rd_ptr_q;
      word_cnt_d = word_cnt_q + LEN_WIDTH'(1);
`ifdef FIFO_RD_CHECKSUM_EN
      sum_d      = sum_q + mem_q[rd_ptr_q];
`endif
    end
    if (re) begin
      issued_d = issued_q + LEN_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d      = bus.burst_len;
          issued_d   = '0;
          word_cnt_d = '0;
`ifdef FIFO_RD_CHECKSUM_EN
          sum_d      = '0;
`endif
          state_d    = (bus.burst_len != '0) ? READ : DONE;
        end
      end
      READ: begin
        if (re && (issued_d == len_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (word_cnt_d == len_q)) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == READ) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      word_cnt_q <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef FIFO_RD_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      word_cnt_q <= word_cnt_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      mem_q      <= mem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef FIFO_RD_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign bus.fifo_re   = re;
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.word_cnt  = word_cnt_q;
`ifdef FIFO_RD_CHECKSUM_EN
  assign bus.checksum  = sum_q;
`endif
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a behavioural 1-cycle-latency FIFO and an acceptance log.
module tb_fifo_rd_ctrl;
  localparam int DW = 8;
  localparam int LW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_rd_ctrl_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();
  fifo_rd_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (.clk(clk), .rst(rst_n), .bus(bus));

  logic [DW-1:0] fmem [0:255];
  logic [DW-1:0] acc_log [0:255];
  int  wr_idx = 0;
  int  rd_idx = 0;
  int  rd_total = 0;
  int  acc_cnt = 0;
  int  re_viol = 0;
  int  re_cnt = 0;
  logic flush = 1'b0;
  int  n_checks = 0;
  int  n_fail = 0;

  assign bus.fifo_empty = (rd_idx == wr_idx);

  always @(posedge clk) begin
    if (bus.fifo_re === 1'b1 && bus.fifo_empty) re_viol <= re_viol + 1;
    if (bus.fifo_re === 1'b1) re_cnt <= re_cnt + 1;
    if (flush) rd_idx <= wr_idx;
    else if (bus.fifo_re === 1'b1 && !bus.fifo_empty) begin
      bus.fifo_dataout <= fmem[rd_idx];
      rd_idx   <= rd_idx + 1;
      rd_total <= rd_total + 1;
    end
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      acc_log[acc_cnt] <= bus.out_data;
      acc_cnt <= acc_cnt + 1;
    end
  end

  task automatic push(input logic [DW-1:0] v);
    fmem[wr_idx] = v;
    wr_idx = wr_idx + 1;
  endtask

  task automatic do_flush();
    @(negedge clk) flush = 1'b1;
    @(negedge clk) flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b0; bus.burst_len = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.fifo_re, bus.out_valid, bus.busy, bus.done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: re/valid/busy/done=%b required 0000",
                         {bus.fifo_re, bus.out_valid, bus.busy, bus.done});
    end
    n_checks++;
    if (bus.out_data !== 8'd0 || bus.word_cnt !== 5'd0) begin
      n_fail++; $display("FAIL reset_data: out_data=%0d word_cnt=%0d required 0 0", bus.out_data, bus.word_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b required 0", bus.busy); end
  endtask

  task automatic test_full_burst();
    int viol0;
    do_flush();
    for (int i = 0; i < 16; i++) push(DW'(i));
    bus.out_ready = 1'b1; viol0 = re_viol;
    @(negedge clk) begin bus.start = 1'b1; bus.burst_len = 5'd16; end
    @(negedge clk) bus.start = 1'b0;
    n_checks++;
    if ({bus.busy, bus.out_valid, bus.fifo_re} !== 3'b101) begin
      n_fail++; $display("FAIL full_e0: busy/valid/re=%b required 101", {bus.busy, bus.out_valid, bus.fifo_re});
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL full_e1: out_valid=%b required 0", bus.out_valid); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, DW'(k)}) begin
        n_fail++; $display("FAIL full_word%0d: valid=%b data=%0d required 1 %0d", k, bus.out_valid, bus.out_data, k);
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1 || bus.word_cnt !== 5'd16) begin
      n_fail++; $display("FAIL full_done: done=%b word_cnt=%0d required 1 16", bus.done, bus.word_cnt);
    end
`ifdef FIFO_RD_CHECKSUM_EN
    n_checks++;
    if (bus.checksum !== 8'h78) begin n_fail++; $display("FAIL full_checksum: %0h required 78", bus.checksum); end
`endif
    @(negedge clk);
    n_checks++;
    if ({bus.done, bus.busy} !== 2'b00 || bus.word_cnt !== 5'd16) begin
      n_fail++; $display("FAIL full_after: done/busy=%b word_cnt=%0d required 00 16", {bus.done, bus.busy}, bus.word_cnt);
    end
    n_checks++;
    if (re_viol !== viol0) begin n_fail++; $display("FAIL full_re_empty: violations=%0d required %0d", re_viol, viol0); end
  endtask

  task automatic test_zero_len();
    int rc0;
    do_flush();
    push(8'hAA);
    rc0 = re_cnt;
    @(negedge clk) begin bus.start = 1'b1; bus.burst_len = 5'd0; end
    @(negedge clk) bus.start = 1'b0;
    n_checks++;
    if ({bus.done, bus.busy} !== 2'b10 || bus.word_cnt !== 5'd0) begin
      n_fail++; $display("FAIL zero_done: done/busy=%b word_cnt=%0d required 10 0", {bus.done, bus.busy}, bus.word_cnt);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL zero_pulse: done=%b required 0", bus.done); end
    n_checks++;
    if (re_cnt !== rc0) begin n_fail++; $display("FAIL zero_re: reads=%0d required %0d", re_cnt - rc0, 0); end
  endtask

  task automatic test_ready_toggle();
    int base, rbase, maxu, u;
    logic hold_pending, done_seen;
    logic [DW-1:0] held;
    do_flush();
    for (int i = 0; i < 6; i++) push(DW'(i));
    base = acc_cnt; rbase = rd_total; maxu = 0; hold_pending = 1'b0; done_seen = 1'b0; held = '0;
    @(negedge clk) begin bus.start = 1'b1; bus.burst_len = 5'd4; bus.out_ready = 1'b1; end
    for (int i = 0; i < 60 && !done_seen; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (hold_pending) begin
        n_checks++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, held}) begin
          n_fail++; $display("FAIL toggle_hold: valid=%b data=%0d required 1 %0d", bus.out_valid, bus.out_data, held);
        end
      end
      bus.out_ready = ~bus.out_ready;
      hold_pending = bus.out_valid && !bus.out_ready;
      held = bus.out_data;
      u = (rd_total - rbase) - (acc_cnt - base);
      if (u > maxu) maxu = u;
      if (bus.done === 1'b1) done_seen = 1'b1;
    end
    bus.out_ready = 1'b1;
    n_checks++;
    if (!done_seen || bus.word_cnt !== 5'd4) begin
      n_fail++; $display("FAIL toggle_done: done_seen=%b word_cnt=%0d required 1 4", done_seen, bus.word_cnt);
    end
    n_checks++;
    if (acc_cnt - base !== 4 || rd_total - rbase !== 4) begin
      n_fail++; $display("FAIL toggle_count: accepted=%0d reads=%0d required 4 4", acc_cnt - base, rd_total - rbase);
    end
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (acc_log[base+j] !== DW'(j)) begin
        n_fail++; $display("FAIL toggle_word%0d: got %0d required %0d", j, acc_log[base+j], j);
      end
    end
    n_checks++;
    if (maxu > 2) begin n_fail++; $display("FAIL toggle_occupancy: max unaccepted=%0d required <=2", maxu); end
`ifdef FIFO_RD_CHECKSUM_EN
    n_checks++;
    if (bus.checksum !== 8'd6) begin n_fail++; $display("FAIL toggle_checksum: %0d required 6", bus.checksum); end
`endif
  endtask

  task automatic test_stall();
    int base;
    do_flush();
    push(8'd20); push(8'd21);
    base = acc_cnt; bus.out_ready = 1'b1;
    @(negedge clk) begin bus.start = 1'b1; bus.burst_len = 5'd5; end
    @(negedge clk) bus.start = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.fifo_re} !== 3'b100 || bus.word_cnt !== 5'd2) begin
      n_fail++; $display("FAIL stall_mid: busy/done/re=%b word_cnt=%0d required 100 2",
                         {bus.busy, bus.done, bus.fifo_re}, bus.word_cnt);
    end
    push(8'd22); push(8'd23); push(8'd24);
    for (int i = 0; i < 40 && bus.done !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1 || bus.word_cnt !== 5'd5) begin
      n_fail++; $display("FAIL stall_done: done=%b word_cnt=%0d required 1 5", bus.done, bus.word_cnt);
    end
    for (int j = 0; j < 5; j++) begin
      n_checks++;
      if (acc_log[base+j] !== DW'(20 + j)) begin
        n_fail++; $display("FAIL stall_word%0d: got %0d required %0d", j, acc_log[base+j], 20 + j);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    do_flush();
    for (int i = 0; i < 8; i++) push(DW'(30 + i));
    base = acc_cnt; bus.out_ready = 1'b1;
    @(negedge clk) begin bus.start = 1'b1; bus.burst_len = 5'd8; end
    for (int i = 0; i < 30 && (acc_cnt - base) < 3; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    n_checks++;
    if (acc_cnt - base !== 3) begin n_fail++; $display("FAIL rmid_reach3: accepted=%0d required 3", acc_cnt - base); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.fifo_re, bus.out_valid, bus.busy, bus.done} !== 4'b0000 || bus.out_data !== 8'd0 || bus.word_cnt !== 5'd0) begin
      n_fail++; $display("FAIL rmid_async: re/valid/busy/done=%b data=%0d cnt=%0d required 0000 0 0",
                         {bus.fifo_re, bus.out_valid, bus.busy, bus.done}, bus.out_data, bus.word_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1; base = acc_cnt; bus.start = 1'b1; bus.burst_len = 5'd2;
    @(negedge clk) bus.start = 1'b0;
    for (int i = 0; i < 30 && bus.done !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1 || bus.word_cnt !== 5'd2 || acc_cnt - base !== 2) begin
      n_fail++; $display("FAIL rmid_done: done=%b word_cnt=%0d accepted=%0d required 1 2 2", bus.done, bus.word_cnt, acc_cnt - base);
    end
    n_checks++;
    if (acc_log[base] !== 8'd35 || acc_log[base+1] !== 8'd36) begin
      n_fail++; $display("FAIL rmid_words: got %0d %0d required 35 36", acc_log[base], acc_log[base+1]);
    end
`ifdef FIFO_RD_CHECKSUM_EN
    n_checks++;
    if (bus.checksum !== 8'd71) begin n_fail++; $display("FAIL rmid_checksum: %0d required 71", bus.checksum); end
`endif
  endtask

  task automatic test_start_while_busy();
    int base;
    do_flush();
    for (int i = 0; i < 10; i++) push(DW'(40 + i));
    base = acc_cnt; bus.out_ready = 1'b1;
    @(negedge clk) begin bus.start = 1'b1; bus.burst_len = 5'd3; end
    @(negedge clk) bus.start = 1'b0;
    @(negedge clk) begin bus.start = 1'b1; bus.burst_len = 5'd7; end
    @(negedge clk) bus.start = 1'b0;
    for (int i = 0; i < 30 && bus.done !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1 || bus.word_cnt !== 5'd3) begin
      n_fail++; $display("FAIL busy_done: done=%b word_cnt=%0d required 1 3", bus.done, bus.word_cnt);
    end
    bus.start = 1'b1; bus.burst_len = 5'd5;
    @(negedge clk) bus.start = 1'b0;
    n_checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++; $display("FAIL busy_done_start: busy/done=%b required 00", {bus.busy, bus.done});
    end
    n_checks++;
    if (acc_cnt - base !== 3 || acc_log[base] !== 8'd40 || acc_log[base+2] !== 8'd42) begin
      n_fail++; $display("FAIL busy_words: accepted=%0d first=%0d last=%0d required 3 40 42",
                         acc_cnt - base, acc_log[base], acc_log[base+2]);
    end
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle: busy=%b required 0", bus.busy); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_burst();
    test_zero_len();
    test_ready_toggle();
    test_stall();
    test_reset_mid();
    test_start_while_busy();
    do_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
